// File: rtl/detector_flancos_multi_pkg.sv
// Shared types for the multi-channel edge detector: edge mode encoding and
// the debounce counter width helper.
package flanco_pkg;

  typedef enum logic [1:0] {
    FLANCO_SUBIDA = 2'b00,
    FLANCO_BAJADA = 2'b01,
    FLANCO_AMBOS  = 2'b10,
    DESHABILITADO = 2'b11
  } modo_flanco_t;

  // Wide enough to hold DEBOUNCE_CICLOS itself, so the DEBOUNCE_CICLOS=1 case stays legal.
  function automatic int ancho_contador(input int ciclos);
    return $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/detector_flancos_multi_if.sv
// Bundle of per-channel inputs, global mode and per-channel status outputs.
// No handshake: levels are sampled every clock, outputs are always valid.
interface detector_flancos_multi_if
  import flanco_pkg::*;
#(
  parameter int N_CANALES = 4
) ();

  logic [N_CANALES-1:0] senal_entrada;
  modo_flanco_t         modo;
  logic [N_CANALES-1:0] limpiar;
  logic [N_CANALES-1:0] nivel_filtrado;
  logic [N_CANALES-1:0] pulso_flanco;
  logic [N_CANALES-1:0] evento_pendiente;
  logic [N_CANALES-1:0] desborde;

  modport master (
    output senal_entrada, modo, limpiar,
    input  nivel_filtrado, pulso_flanco, evento_pendiente, desborde
  );

  modport slave (
    input  senal_entrada, modo, limpiar,
    output nivel_filtrado, pulso_flanco, evento_pendiente, desborde
  );

endinterface

// File: rtl/detector_flancos_multi_canal.sv
// One channel: synchroniser, debounce filter, mode-qualified edge pulse, sticky flags.
// Latency N_SYNC+DEBOUNCE_CICLOS-1 edges from first sample to level/pulse; no backpressure.
module canal_flanco
  import flanco_pkg::*;
#(
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         senal,
  input  modo_flanco_t modo,
  input  logic         limpiar,
  output logic         nivel,
  output logic         pulso,
  output logic         evento,
  output logic         desborde
);

  localparam int             CW      = ancho_contador(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0]  CNT_FIN = CW'(DEBOUNCE_CICLOS - 1);

  logic [N_SYNC-1:0] sync_q;
  logic [CW-1:0]     cnt_q;
  logic              nivel_q;
  logic              pulso_q;
  logic              evento_q;
  logic              desborde_q;

  logic sinc;
  logic difiere;
  logic conmuta;
  logic pulso_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], senal};
    end
  end

  assign sinc    = sync_q[N_SYNC-1];
  assign difiere = (sinc != nivel_q);
  assign conmuta = difiere && (cnt_q == CNT_FIN);

  // Pulse qualification uses the mode present at the toggle edge, so a mode
  // change alone can never produce a pulse.
  always_comb begin
    pulso_d = 1'b0;
    case (modo)
      FLANCO_SUBIDA: pulso_d = conmuta && !nivel_q;
      FLANCO_BAJADA: pulso_d = conmuta &&  nivel_q;
      FLANCO_AMBOS:  pulso_d = conmuta;
      default:       pulso_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      if (!difiere || conmuta) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      nivel_q <= nivel_q ^ conmuta;
      pulso_q <= pulso_d;
    end
  end

  // A clear that coincides with a new pulse keeps the new event and drops the overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evento_q   <= 1'b0;
      desborde_q <= 1'b0;
    end else if (limpiar && pulso_q) begin
      evento_q   <= 1'b1;
      desborde_q <= 1'b0;
    end else if (limpiar) begin
      evento_q   <= 1'b0;
      desborde_q <= 1'b0;
    end else if (pulso_q) begin
      if (evento_q) begin
        desborde_q <= 1'b1;
      end
      evento_q <= 1'b1;
    end
  end

  assign nivel    = nivel_q;
  assign pulso    = pulso_q;
  assign evento   = evento_q;
  assign desborde = desborde_q;

endmodule

// File: rtl/detector_flancos_multi.sv
// Multi-channel edge detector: N_CANALES independent canal_flanco instances sharing one mode.
// Latency N_SYNC+DEBOUNCE_CICLOS-1 edges input to pulse; no backpressure, pulses are never held.
module detector_flancos_multi
  import flanco_pkg::*;
#(
  parameter int N_CANALES       = 4,
  parameter int N_SYNC          = 2,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input logic                    clk,
  input logic                    rst,
  detector_flancos_multi_if.slave bus
);

  logic [N_CANALES-1:0] nivel_v;
  logic [N_CANALES-1:0] pulso_v;
  logic [N_CANALES-1:0] evento_v;
  logic [N_CANALES-1:0] desborde_v;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    canal_flanco #(
      .N_SYNC          (N_SYNC),
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .senal    (bus.senal_entrada[i]),
      .modo     (bus.modo),
      .limpiar  (bus.limpiar[i]),
      .nivel    (nivel_v[i]),
      .pulso    (pulso_v[i]),
      .evento   (evento_v[i]),
      .desborde (desborde_v[i])
    );
  end

  assign bus.nivel_filtrado   = nivel_v;
  assign bus.pulso_flanco     = pulso_v;
  assign bus.evento_pendiente = evento_v;
  assign bus.desborde         = desborde_v;

endmodule

// File: tb/tb_detector_flancos_multi.sv
// Directed bench for detector_flancos_multi; expected pulses are queued with their
// due cycle when stimulus is driven and checked against pulso_flanco every cycle.
module tb_detector_flancos_multi;
  import flanco_pkg::*;

  typedef struct {
    int         ciclo;
    logic [3:0] pulso;
  } esperado_t;

  logic clk;
  logic rst;
  int   ciclo;
  int   n_asserts;
  int   n_fail;
  esperado_t cola[$];

  detector_flancos_multi_if #(.N_CANALES(4)) ifc ();

  detector_flancos_multi #(
    .N_CANALES       (4),
    .N_SYNC          (2),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, ciclo);
    end
  endtask

  // Expected pulse due 'rel' cycles after the edge just passed.
  task automatic push(input int rel, input logic [3:0] m);
    esperado_t e;
    e.ciclo = ciclo + rel;
    e.pulso = m;
    cola.push_back(e);
  endtask

  task automatic tick();
    logic [3:0] exp;
    esperado_t  e;
    @(posedge clk);
    ciclo++;
    @(negedge clk);
    exp = 4'h0;
    if (cola.size() > 0 && cola[0].ciclo == ciclo) begin
      e   = cola.pop_front();
      exp = e.pulso;
    end
    chk("pulso_flanco", ifc.pulso_flanco, exp);
  endtask

  task automatic espera(input int n);
    repeat (n) tick();
  endtask

  task automatic limpiar_todo();
    ifc.limpiar = 4'hF;
    tick();
    ifc.limpiar = 4'h0;
  endtask

  initial begin
    ciclo     = 0;
    n_asserts = 0;
    n_fail    = 0;
    rst               = 1'b0;
    ifc.senal_entrada = 4'hF;
    ifc.modo          = FLANCO_SUBIDA;
    ifc.limpiar       = 4'h0;

    // 1. Reset with inputs high
    espera(3);
    chk("rst_nivel", ifc.nivel_filtrado, 4'h0);
    chk("rst_evento", ifc.evento_pendiente, 4'h0);
    chk("rst_desborde", ifc.desborde, 4'h0);
    rst = 1'b1;
    push(6, 4'hF);
    espera(5);
    chk("lat_nivel_pre", ifc.nivel_filtrado, 4'h0);
    espera(1);
    chk("lat_nivel", ifc.nivel_filtrado, 4'hF);
    chk("lat_evento_pre", ifc.evento_pendiente, 4'h0);
    espera(1);
    chk("lat_evento", ifc.evento_pendiente, 4'hF);
    chk("lat_desborde", ifc.desborde, 4'h0);
    limpiar_todo();
    chk("limpiar_evento", ifc.evento_pendiente, 4'h0);
    ifc.senal_entrada = 4'h0;
    espera(8);
    chk("bajada_modo00_nivel", ifc.nivel_filtrado, 4'h0);
    chk("bajada_modo00_evento", ifc.evento_pendiente, 4'h0);

    // 2. Glitch rejection on ch0
    ifc.senal_entrada[0] = 1'b1;
    espera(3);
    ifc.senal_entrada[0] = 1'b0;
    espera(8);
    chk("glitch3_nivel", ifc.nivel_filtrado, 4'h0);
    chk("glitch3_evento", ifc.evento_pendiente, 4'h0);
    ifc.senal_entrada[0] = 1'b1;
    push(6, 4'h1);
    espera(4);
    ifc.senal_entrada[0] = 1'b0;
    espera(2);
    chk("glitch4_nivel", ifc.nivel_filtrado, 4'h1);
    espera(12);
    chk("glitch4_nivel_fin", ifc.nivel_filtrado, 4'h0);
    chk("glitch4_evento", ifc.evento_pendiente, 4'h1);
    chk("glitch4_desborde", ifc.desborde, 4'h0);
    limpiar_todo();

    // 3. Falling mode on ch1
    ifc.modo = FLANCO_BAJADA;
    ifc.senal_entrada[1] = 1'b1;
    espera(10);
    chk("bajada_nivel_alto", ifc.nivel_filtrado, 4'h2);
    chk("bajada_sin_evento", ifc.evento_pendiente, 4'h0);
    ifc.senal_entrada[1] = 1'b0;
    push(6, 4'h2);
    espera(10);
    chk("bajada_nivel", ifc.nivel_filtrado, 4'h0);
    chk("bajada_evento", ifc.evento_pendiente, 4'h2);
    limpiar_todo();

    // 4. Both edges and overflow on ch2
    ifc.modo = FLANCO_AMBOS;
    ifc.senal_entrada[2] = 1'b1;
    push(6, 4'h4);
    espera(10);
    chk("ambos_evento1", ifc.evento_pendiente, 4'h4);
    chk("ambos_desborde1", ifc.desborde, 4'h0);
    ifc.senal_entrada[2] = 1'b0;
    push(6, 4'h4);
    espera(10);
    chk("ambos_evento2", ifc.evento_pendiente, 4'h4);
    chk("ambos_desborde2", ifc.desborde, 4'h4);
    ifc.limpiar = 4'h4;
    tick();
    ifc.limpiar = 4'h0;
    chk("limpiar_ch2_evento", ifc.evento_pendiente, 4'h0);
    chk("limpiar_ch2_desborde", ifc.desborde, 4'h0);
    ifc.senal_entrada[2] = 1'b1;
    push(6, 4'h4);
    espera(10);
    chk("pend_evento", ifc.evento_pendiente, 4'h4);
    ifc.senal_entrada[2] = 1'b0;
    push(6, 4'h4);
    espera(6);
    ifc.limpiar = 4'h4;
    tick();
    ifc.limpiar = 4'h0;
    chk("limpiar_y_pulso_evento", ifc.evento_pendiente, 4'h4);
    chk("limpiar_y_pulso_desborde", ifc.desborde, 4'h0);
    espera(3);

    // 5. Async reset mid-debounce on ch3 (ch2 event still pending here)
    ifc.senal_entrada[3] = 1'b1;
    espera(4);
    #10;
    rst = 1'b0;
    #1;
    chk("rst_async_nivel", ifc.nivel_filtrado, 4'h0);
    chk("rst_async_pulso", ifc.pulso_flanco, 4'h0);
    chk("rst_async_evento", ifc.evento_pendiente, 4'h0);
    chk("rst_async_desborde", ifc.desborde, 4'h0);
    ifc.senal_entrada[3] = 1'b0;
    tick();
    rst = 1'b1;
    espera(12);
    chk("rst_async_nivel_fin", ifc.nivel_filtrado, 4'h0);
    chk("rst_async_evento_fin", ifc.evento_pendiente, 4'h0);

    // 6. Disabled mode
    ifc.modo = DESHABILITADO;
    ifc.senal_entrada = 4'hF;
    espera(8);
    chk("dis_nivel_alto", ifc.nivel_filtrado, 4'hF);
    chk("dis_evento_alto", ifc.evento_pendiente, 4'h0);
    ifc.senal_entrada = 4'h0;
    espera(8);
    chk("dis_nivel_bajo", ifc.nivel_filtrado, 4'h0);
    chk("dis_desborde", ifc.desborde, 4'h0);
    ifc.senal_entrada = 4'hF;
    espera(8);
    chk("dis_nivel_alto2", ifc.nivel_filtrado, 4'hF);
    ifc.modo = FLANCO_SUBIDA;
    espera(8);
    chk("cambio_modo_evento", ifc.evento_pendiente, 4'h0);
    chk("cambio_modo_nivel", ifc.nivel_filtrado, 4'hF);

    n_asserts++;
    assert (cola.size() == 0)
    else begin
      n_fail++;
      $error("FAIL cola_pendiente observed=%0d expected=0", cola.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
